// File: rtl/serial_add_arbiter_pkg.sv
// Shared definitions for the serial-add arbiter slice: FSM encoding and default width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_arbiter_adder.sv
// One-bit serial full adder with a registered carry, reused for every operation.
module serial_adder_core (
    input  logic clk,
    input  logic rst_n,
    input  logic vld,
    input  logic a,
    input  logic b,
    input  logic last,
    output logic sum,
    output logic cout
);

    logic carry;

    assign sum  = a ^ b ^ carry;
    assign cout = (a & b) | (carry & (a ^ b));

    // The last bit's carry-out is exported combinationally, so the register can
    // drop to zero on that edge and the next operation starts with carry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (vld) begin
            carry <= last ? 1'b0 : cout;
        end
    end

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end feeding one bit-serial adder, LSB first.
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_vld,
    output logic [1:0]       req_rdy,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             last_gnt;
    logic [1:0]       gnt;
    logic             accept;
    logic             ser_vld;
    logic             ser_last;
    logic             ser_sum;
    logic             ser_cout;

    // last_gnt resets to 1 so that requester 0 wins the first contention.
    always_comb begin
        gnt = '0;
        case (req_vld)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    assign req_rdy  = (rst_n && state == IDLE) ? gnt : '0;
    assign accept   = |(req_vld & req_rdy);
    assign ser_vld  = (state == SHIFT);
    assign ser_last = ser_vld && (cnt == LAST_CNT);

    serial_adder_core u_adder (
        .clk   (clk),
        .rst_n (rst_n),
        .vld   (ser_vld),
        .a     (a_q[cnt]),
        .b     (b_q[cnt]),
        .last  (ser_last),
        .sum   (ser_sum),
        .cout  (ser_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            last_gnt <= 1'b1;
            rsp_vld  <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= gnt[1] ? req_a1 : req_a0;
                        b_q      <= gnt[1] ? req_b1 : req_b0;
                        rsp_id   <= gnt[1];
                        last_gnt <= gnt[1];
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    rsp_sum[cnt] <= ser_sum;
                    cnt          <= cnt + 1'b1;
                    if (ser_last) begin
                        rsp_cout <= ser_cout;
                        rsp_vld  <= 1'b1;
                        cnt      <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter at WIDTH=8.
module tb_serial_add_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       req_vld = '0;
    logic [1:0]       req_rdy;
    logic [WIDTH-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic             rsp_vld;
    logic             rsp_rdy = 1'b1;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_a0   (req_a0),
        .req_b0   (req_b0),
        .req_a1   (req_a1),
        .req_b1   (req_b1),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_cout (rsp_cout)
    );

    function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0] s;
        s      = {1'b0, a} + {1'b0, b};
        e.id   = id;
        e.sum  = s[WIDTH-1:0];
        e.cout = s[WIDTH];
        return e;
    endfunction

    // Bounded wait for rsp_vld; returns the number of edges taken.
    task automatic wait_rsp(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (rsp_vld !== 1'b1 && cycles < limit);
    endtask

    task automatic test_reset();
        req_vld = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (req_rdy !== 2'b00) $display("FAIL reset_req_rdy: got %b want 00", req_rdy);
        else pass_cnt++;
        total_cnt++;
        if ({rsp_vld, rsp_id, rsp_sum, rsp_cout} !== '0)
            $display("FAIL reset_outputs: got vld=%b id=%b sum=%h cout=%b want all 0", rsp_vld, rsp_id, rsp_sum, rsp_cout);
        else pass_cnt++;
        req_vld = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({req_rdy, rsp_vld} !== 3'b000) $display("FAIL reset_idle: got rdy=%b vld=%b want 00/0", req_rdy, rsp_vld);
        else pass_cnt++;
    endtask

    task automatic test_single();
        exp_t e;
        int   cyc;
        sb.push_back(model(1'b0, 8'h5A, 8'h3C));
        req_a0 = 8'h5A; req_b0 = 8'h3C; req_vld = 2'b01;
        #1;
        total_cnt++;
        if (req_rdy !== 2'b01) $display("FAIL single_grant: got %b want 01", req_rdy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req_vld = 2'b00; req_a0 = 8'hFF; req_b0 = 8'hFF;
        wait_rsp(20, cyc);
        total_cnt++;
        if (cyc + 1 != WIDTH + 1 || rsp_vld !== 1'b1)
            $display("FAIL single_latency: got %0d cycles vld=%b want %0d", cyc + 1, rsp_vld, WIDTH + 1);
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout})
            $display("FAIL single_rsp: got id=%b sum=%h cout=%b want id=%b sum=%h cout=%b", rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_vld !== 1'b0) $display("FAIL single_release: got vld=%b want 0", rsp_vld);
        else pass_cnt++;
    endtask

    task automatic test_carry_chain();
        logic [WIDTH-1:0] a_tab [2];
        logic [WIDTH-1:0] b_tab [2];
        exp_t e;
        int   cyc;
        a_tab = '{8'hFF, 8'h01};
        b_tab = '{8'h01, 8'h01};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(model(1'b1, a_tab[i], b_tab[i]));
            req_a1 = a_tab[i]; req_b1 = b_tab[i]; req_vld = 2'b10;
            @(posedge clk);
            #1;
            req_vld = 2'b00;
            wait_rsp(20, cyc);
            total_cnt++;
            if (cyc + 1 != WIDTH + 1) $display("FAIL carry_latency%0d: got %0d want %0d", i, cyc + 1, WIDTH + 1);
            else pass_cnt++;
            e = sb.pop_front();
            total_cnt++;
            if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout})
                $display("FAIL carry_rsp%0d: got id=%b sum=%h cout=%b want id=%b sum=%h cout=%b", i, rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        req_a0 = 8'h80; req_b0 = 8'h80; req_a1 = 8'h10; req_b1 = 8'h20;
        for (int i = 0; i < 4; i++)
            sb.push_back((i % 2 == 0) ? model(1'b0, 8'h80, 8'h80) : model(1'b1, 8'h10, 8'h20));
        req_vld = 2'b11;
        #1;
        total_cnt++;
        if (req_rdy !== 2'b01) $display("FAIL rr_first_grant: got %b want 01", req_rdy);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(30, cyc);
            e = sb.pop_front();
            total_cnt++;
            if ({rsp_vld, rsp_id, rsp_sum, rsp_cout} !== {1'b1, e.id, e.sum, e.cout})
                $display("FAIL rr_rsp%0d: got vld=%b id=%b sum=%h cout=%b want vld=1 id=%b sum=%h cout=%b", i, rsp_vld, rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
            else pass_cnt++;
            total_cnt++;
            if (req_rdy !== 2'b00) $display("FAIL rr_done_rdy%0d: got %b want 00", i, req_rdy);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (cyc != WIDTH + 2) $display("FAIL rr_period%0d: got %0d want %0d", i, cyc, WIDTH + 2);
                else pass_cnt++;
            end
        end
        req_vld = 2'b00;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({rsp_vld, req_rdy} !== 3'b000) $display("FAIL rr_release: got vld=%b rdy=%b want 0/00", rsp_vld, req_rdy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        rsp_rdy = 1'b0;
        e = model(1'b0, 8'h33, 8'h44);
        sb.push_back(e);
        req_a0 = 8'h33; req_b0 = 8'h44; req_vld = 2'b01;
        @(posedge clk);
        #1;
        req_vld = 2'b11;
        req_a0 = WIDTH'($urandom); req_b0 = WIDTH'($urandom);
        req_a1 = WIDTH'($urandom); req_b1 = WIDTH'($urandom);
        wait_rsp(20, cyc);
        e = sb.pop_front();
        total_cnt++;
        if ({rsp_vld, rsp_id, rsp_sum, rsp_cout} !== {1'b1, e.id, e.sum, e.cout})
            $display("FAIL bp_rsp: got vld=%b id=%b sum=%h cout=%b want vld=1 id=%b sum=%h cout=%b", rsp_vld, rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if ({rsp_vld, rsp_id, rsp_sum, rsp_cout, req_rdy} !== {1'b1, e.id, e.sum, e.cout, 2'b00})
                $display("FAIL bp_stall%0d: got vld=%b id=%b sum=%h cout=%b rdy=%b want vld=1 id=%b sum=%h cout=%b rdy=00", i, rsp_vld, rsp_id, rsp_sum, rsp_cout, req_rdy, e.id, e.sum, e.cout);
            else pass_cnt++;
        end
        req_vld = 2'b00;
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_vld !== 1'b0) $display("FAIL bp_release: got vld=%b want 0", rsp_vld);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({rsp_vld, req_rdy} !== 3'b000) $display("FAIL bp_single_handshake: got vld=%b rdy=%b want 0/00", rsp_vld, req_rdy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        int   cyc;
        req_a0 = 8'hFF; req_b0 = 8'hFF; req_vld = 2'b01;
        @(posedge clk);
        #1;
        req_vld = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        req_vld = 2'b11;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({rsp_vld, rsp_id, rsp_sum, rsp_cout, req_rdy} !== '0)
            $display("FAIL mid_reset_outputs: got vld=%b id=%b sum=%h cout=%b rdy=%b want all 0", rsp_vld, rsp_id, rsp_sum, rsp_cout, req_rdy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_a0 = 8'h11; req_b0 = 8'h22; req_a1 = 8'h55; req_b1 = 8'h66;
        sb.push_back(model(1'b0, 8'h11, 8'h22));
        #1;
        total_cnt++;
        if (req_rdy !== 2'b01) $display("FAIL mid_reset_priority: got %b want 01", req_rdy);
        else pass_cnt++;
        @(posedge clk);
        #1;
        req_vld = 2'b00;
        wait_rsp(20, cyc);
        total_cnt++;
        if (cyc + 1 != WIDTH + 1) $display("FAIL mid_reset_latency: got %0d want %0d", cyc + 1, WIDTH + 1);
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout})
            $display("FAIL mid_reset_rsp: got id=%b sum=%h cout=%b want id=%b sum=%h cout=%b", rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_vld !== 1'b0) $display("FAIL mid_reset_release: got vld=%b want 0", rsp_vld);
        else pass_cnt++;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        test_reset();
        test_single();
        test_carry_chain();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_vld  input  2  per-requester request valid; index 0 = requester 0.
REQ-005 req_rdy  output  2  per-requester ready; req_vld[i] & req_rdy[i] = accepted.
REQ-006 req_a0, req_b0  input  WIDTH each  requester 0 operands.
REQ-007 req_a1, req_b1  input  WIDTH each  requester 1 operands.
REQ-008 rsp_vld  output  1  result valid.
REQ-009 rsp_rdy  input  1  result consumer ready.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_sum  output  WIDTH  sum modulo 2^WIDTH.
REQ-012 rsp_cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 One shared bit-serial adder SHALL perform all additions; the block arbitrates, serializes operands LSB-first, and deserializes sum bits.
REQ-014 FSM states: IDLE, SHIFT, DONE.
REQ-015 IDLE: req_rdy SHALL be one-hot to the granted requester (or 0 if no req_vld); on acceptance, operands and id are latched and state moves to SHIFT with bit counter = 0.
REQ-016 Arbitration is round-robin: if both request, grant the requester not granted last; after reset, requester 0 has priority.
REQ-017 req_rdy SHALL be 2'b00 in SHIFT and DONE.
REQ-018 SHIFT: each cycle, drive vld=1, a=latched_a[cnt], b=latched_b[cnt], last=(cnt==WIDTH-1) into the serial adder; capture sum bit into result[cnt]; increment cnt.
REQ-019 Serial adder: sum = a^b^carry (combinational); carry updates on vld; carry is cleared on the cycle following last, so each operation starts with carry 0.
REQ-020 After the bit with last=1, state SHALL be DONE; rsp_cout = carry out produced by that bit.
REQ-021 Latency: acceptance edge to rsp_vld=1 is exactly WIDTH+1 cycles; with rsp_rdy held high, back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 DONE: rsp_vld=1; rsp_id, rsp_sum, rsp_cout stable until rsp_vld & rsp_rdy; then return to IDLE.
REQ-023 rsp_rdy low in DONE SHALL stall indefinitely without corrupting the result or accepting new requests.
REQ-024 A requester deasserting req_vld before acceptance loses nothing; the pointer advances only on acceptance.
REQ-025 Operand changes on req_a*/req_b* after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-026 Assertion of rst_n=0 at any time, including mid-SHIFT or DONE, SHALL immediately force: state IDLE, cnt 0, carry 0, round-robin pointer to favour requester 0, rsp_vld 0, rsp_id 0, rsp_sum 0, rsp_cout 0; the in-flight operation is discarded.
REQ-027 req_rdy SHALL be 0 while rst_n=0.

Structure
REQ-028 Package serial_add_pkg SHALL hold the FSM state enum (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-029 The bit-serial adder SHALL be a separate sub-module, serial_adder_core (clk, rst_n, vld, a, b, last -> sum, cout), instantiated once.
REQ-030 Bit counter width SHALL be $clog2(WIDTH).

Verification (WIDTH=8)
REQ-031 Single request: req 0, a=0x5A, b=0x3C -> rsp_vld after 9 cycles, rsp_id=0, rsp_sum=0x96, rsp_cout=0.
REQ-032 Carry chain: req 1, a=0xFF, b=0x01 -> rsp_sum=0x00, rsp_cout=1, rsp_id=1; next request 0x01+0x01 -> 0x02, cout 0 (carry cleared).
REQ-033 Contention: both requesters hold req_vld continuously (req0 0x80+0x80, req1 0x10+0x20), rsp_rdy=1 -> grants alternate 0,1,0,1; results 0x00/cout 1 and 0x30/cout 0.
REQ-034 Back-pressure: rsp_rdy=0 for 5 cycles in DONE -> outputs stable, req_rdy=00; release -> exactly one handshake, return to IDLE.
REQ-035 Reset mid-SHIFT at cnt=4 -> all outputs to reset values same cycle; subsequent request 0x11+0x22 -> 0x33, cout 0, grant to requester 0 if both request.
